reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter Q_WIDTH, default 4, which is the ROB tag width; tag 0 means "no producer".
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, which is the architectural register address width.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk_in (in, 1, system clock), then rst_n_in (in, 1, asynchronous reset, active low).
REQ-004 rdy_in  in  1  global enable; low freezes all state.
REQ-005 issue_valid  in  1  issue stage presents an instruction.
REQ-006 issue_has_rd  in  1  instruction writes a destination register.
REQ-007 issue_rd  in  REG_ADDR_WIDTH  destination register.
REQ-008 issue_ready  out  1  entry available (not full, rdy_in high, flush_in low).
REQ-009 issue_tag  out  Q_WIDTH  tag allocated on acceptance (current tail).
REQ-010 rd_control / rd / Q_value  out  1 / REG_ADDR_WIDTH / Q_WIDTH  rename request to regfile.
REQ-011 cdb_valid / cdb_tag / cdb_value  in  1 / Q_WIDTH / 32  writeback broadcast.
REQ-012 query1_tag, query2_tag  in  Q_WIDTH  operand tags read from regfile Q1/Q2.
REQ-013 query1_ready, query2_ready  out  1  and query1_value, query2_value  out  32  forwarded operand.
REQ-014 has_commit / commit_target / Commit_Q / Commit_V  out  1 / REG_ADDR_WIDTH / Q_WIDTH / 32  commit to regfile.
REQ-015 flush_in  in  1  synchronous squash of all entries.

Function
REQ-016 Capacity SHALL be 2^Q_WIDTH-1 entries (15 at default), tags 1..2^Q_WIDTH-1; pointer increment wraps from 2^Q_WIDTH-1 to 1, never 0.
REQ-017 Acceptance SHALL occur on a rising edge where issue_valid && issue_ready; the entry at tail is set busy=1, done=0, rd and has_rd latched, tail advances, count increments.
REQ-018 rd_control SHALL be combinational: accept && issue_has_rd && issue_rd!=0; rd=issue_rd, Q_value=issue_tag, so the regfile renames on the same edge.
REQ-019 cdb_valid with a nonzero tag naming a busy entry SHALL set done=1 and store cdb_value on the edge; cdb_tag=0 or a non-busy tag is ignored.
REQ-020 Commit SHALL be combinational from head state: when rdy_in, flush_in low, count!=0 and done[head], the head retires on the edge (head advances, count decrements).
REQ-021 has_commit SHALL be high only for a retiring head with has_rd && rd!=0; commit_target=rd, Commit_Q=head tag, Commit_V=stored value. A retiring head without a destination retires silently.
REQ-022 At most one issue and one commit per cycle; both may occur on the same edge, and count then stays unchanged.
REQ-023 A CDB write to the head SHALL NOT commit in the same cycle; minimum writeback-to-commit latency is 1 cycle.
REQ-024 issue_ready SHALL be 0 when count==2^Q_WIDTH-1, even if a commit retires that cycle (no same-cycle slot reuse).
REQ-025 queryN_ready=1 and queryN_value SHALL be valid when done[queryN_tag], or with same-cycle bypass when cdb_valid && cdb_tag==queryN_tag; both outputs are 0 for tag 0.
REQ-026 flush_in SHALL clear all busy/done bits, set head=tail=1 and count=0, and suppress issue and commit in that cycle.
REQ-027 rdy_in low SHALL hold all state, force has_commit=0, rd_control=0 and issue_ready=0, and ignore the CDB.

Reset
REQ-028 rst_n_in low SHALL immediately clear all busy/done bits and set head=tail=1, count=0, so has_commit=0, rd_control=0 and issue_tag=1.
REQ-029 A reset asserted mid-operation SHALL discard all entries without emitting a commit; operation resumes on the first edge after deassertion.

Structure
REQ-030 The shared package SHALL hold Q_WIDTH, REG_ADDR_WIDTH, ROB_SIZE (2^Q_WIDTH-1) and the tag-increment-with-wrap function.
REQ-031 There SHALL be no sub-module; the entry array, pointers and count live in reorder_buffer.

Verification
REQ-032 Reset, then issue rd=5 -> issue_tag=1, rd_control=1, Q_value=1; CDB tag1 value 0xDEADBEEF -> next cycle has_commit=1, commit_target=5, Commit_Q=1, Commit_V=0xDEADBEEF.
REQ-033 Issue 15 instructions -> issue_ready=0 after the 15th; commit of tag 1 in the same cycle as a 16th issue request -> request rejected; next cycle the issue is accepted with tag 1 (wrap).
REQ-034 Issue rd=0 and a store (has_rd=0) -> rd_control=0; on completion both retire in order with has_commit=0.
REQ-035 Complete tag 3 before tags 1 and 2 -> no commit until tag 1 is done; then commits occur in order 1, 2, 3 on consecutive cycles.
REQ-036 query1_tag=2 with cdb_valid, cdb_tag=2, value 0x42 in the same cycle -> query1_ready=1, query1_value=0x42.
REQ-037 With 4 entries in flight, pulse flush_in -> count=0 and the next issue_tag=1; with rdy_in held low for 3 cycles -> no state change and has_commit=0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared sizing constants and tag-pointer arithmetic for the reorder buffer.
// Tag 0 is reserved to mean "no producer", so pointers cycle over 1..2^Q_WIDTH-1.
package reorder_buffer_pkg;

  localparam int Q_WIDTH        = 4;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int ROB_SIZE       = (1 << Q_WIDTH) - 1;

  // Advance a tag pointer, skipping the reserved tag 0 on wrap.
  function automatic logic [31:0] tag_inc(input logic [31:0] tag, input int width);
    logic [31:0] max_tag;
    max_tag = (32'd1 << width) - 32'd1;
    return (tag == max_tag) ? 32'd1 : tag + 32'd1;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags at issue, captures CDB results,
// forwards finished operands and retires the head entry to the register file.
module reorder_buffer #(
  parameter int Q_WIDTH        = reorder_buffer_pkg::Q_WIDTH,
  parameter int REG_ADDR_WIDTH = reorder_buffer_pkg::REG_ADDR_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      issue_valid,
  input  logic                      issue_has_rd,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  output logic                      issue_ready,
  output logic [Q_WIDTH-1:0]        issue_tag,
  output logic                      rd_control,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic [Q_WIDTH-1:0]        Q_value,
  input  logic                      cdb_valid,
  input  logic [Q_WIDTH-1:0]        cdb_tag,
  input  logic [31:0]               cdb_value,
  input  logic [Q_WIDTH-1:0]        query1_tag,
  input  logic [Q_WIDTH-1:0]        query2_tag,
  output logic                      query1_ready,
  output logic [31:0]               query1_value,
  output logic                      query2_ready,
  output logic [31:0]               query2_value,
  output logic                      has_commit,
  output logic [REG_ADDR_WIDTH-1:0] commit_target,
  output logic [Q_WIDTH-1:0]        Commit_Q,
  output logic [31:0]               Commit_V,
  input  logic                      flush_in
);
  import reorder_buffer_pkg::*;

  localparam int                 DEPTH      = 1 << Q_WIDTH;
  localparam logic [Q_WIDTH-1:0] FIRST_TAG  = Q_WIDTH'(1);
  localparam logic [Q_WIDTH-1:0] FULL_COUNT = Q_WIDTH'(DEPTH - 1);

  // Slot 0 exists only so tags index directly; it is never allocated.
  logic [DEPTH-1:0]          busy;
  logic [DEPTH-1:0]          done;
  logic [REG_ADDR_WIDTH-1:0] rd_mem    [DEPTH];
  logic                      has_rd_mem[DEPTH];
  logic [31:0]               value_mem [DEPTH];

  logic [Q_WIDTH-1:0] head, tail, count;
  logic [Q_WIDTH-1:0] head_inc, tail_inc;
  logic               live, accept, commit, cdb_hit;

  assign head_inc = Q_WIDTH'(tag_inc(32'(head), Q_WIDTH));
  assign tail_inc = Q_WIDTH'(tag_inc(32'(tail), Q_WIDTH));

  // A full buffer refuses issue even when the head retires this cycle.
  assign live        = rdy_in && !flush_in;
  assign issue_ready = live && (count != FULL_COUNT);
  assign accept      = issue_valid && issue_ready;
  assign commit      = live && (count != '0) && done[head];
  assign cdb_hit     = live && cdb_valid && (cdb_tag != '0) && busy[cdb_tag];

  assign issue_tag  = tail;
  assign rd_control = accept && issue_has_rd && (issue_rd != '0);
  assign rd         = issue_rd;
  assign Q_value    = tail;

  assign has_commit    = commit && has_rd_mem[head] && (rd_mem[head] != '0);
  assign commit_target = rd_mem[head];
  assign Commit_Q      = head;
  assign Commit_V      = value_mem[head];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; later assignments to the same bit (commit after CDB) win.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy  <= '0;
      done  <= '0;
      head  <= FIRST_TAG;
      tail  <= FIRST_TAG;
      count <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        busy  <= '0;
        done  <= '0;
        head  <= FIRST_TAG;
        tail  <= FIRST_TAG;
        count <= '0;
      end else begin
        if (cdb_hit) done[cdb_tag] <= 1'b1;
        if (commit) begin
          busy[head] <= 1'b0;
          done[head] <= 1'b0;
          head       <= head_inc;
        end
        if (accept) begin
          busy[tail] <= 1'b1;
          done[tail] <= 1'b0;
          tail       <= tail_inc;
        end
        case ({accept, commit})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: payload storage has no reset; busy/done qualify every read, so
  // leaving it unreset keeps it a plain RAM without a reset fan-out.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      rd_mem[tail]     <= issue_rd;
      has_rd_mem[tail] <= issue_has_rd;
    end
    if (cdb_hit) value_mem[cdb_tag] <= cdb_value;
  end

  // NOTE: every output of this block gets a default first, so no latch forms.
  always_comb begin
    query1_ready = 1'b0;
    query1_value = '0;
    if (query1_tag != '0) begin
      if (done[query1_tag]) begin
        query1_ready = 1'b1;
        query1_value = value_mem[query1_tag];
      end else if (cdb_valid && (cdb_tag == query1_tag)) begin
        query1_ready = 1'b1;
        query1_value = cdb_value;
      end
    end
  end

  always_comb begin
    query2_ready = 1'b0;
    query2_value = '0;
    if (query2_tag != '0) begin
      if (done[query2_tag]) begin
        query2_ready = 1'b1;
        query2_value = value_mem[query2_tag];
      end else if (cdb_valid && (cdb_tag == query2_tag)) begin
        query2_ready = 1'b1;
        query2_value = cdb_value;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic,
// all compared against an in-order queue model of the buffer.
module tb_reorder_buffer;

  localparam int QW    = 4;
  localparam int RW    = 5;
  localparam int ROB_N = 15;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          rdy_in, issue_valid, issue_has_rd, flush_in, cdb_valid;
  logic [RW-1:0] issue_rd;
  logic [QW-1:0] cdb_tag, query1_tag, query2_tag;
  logic [31:0]   cdb_value;
  logic          issue_ready, rd_control, query1_ready, query2_ready, has_commit;
  logic [QW-1:0] issue_tag, Q_value, Commit_Q;
  logic [RW-1:0] rd, commit_target;
  logic [31:0]   query1_value, query2_value, Commit_V;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          tag;
    int          rd;
    bit          has_rd;
    bit          done;
    logic [31:0] value;
  } ent_t;

  ent_t rob[$];
  int   next_tag;

  always #5 clk_in = ~clk_in;

  reorder_buffer #(.Q_WIDTH(QW), .REG_ADDR_WIDTH(RW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_has_rd(issue_has_rd), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .issue_tag(issue_tag),
    .rd_control(rd_control), .rd(rd), .Q_value(Q_value),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .query1_tag(query1_tag), .query2_tag(query2_tag),
    .query1_ready(query1_ready), .query1_value(query1_value),
    .query2_ready(query2_ready), .query2_value(query2_value),
    .has_commit(has_commit), .commit_target(commit_target),
    .Commit_Q(Commit_Q), .Commit_V(Commit_V), .flush_in(flush_in)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find(input int t);
    for (int i = 0; i < rob.size(); i++)
      if (rob[i].tag == t) return i;
    return -1;
  endfunction

  task automatic query_expect(input int t, output bit r, output logic [31:0] v);
    int idx;
    r = 1'b0;
    v = '0;
    if (t != 0) begin
      idx = find(t);
      if (idx >= 0 && rob[idx].done) begin
        r = 1'b1;
        v = rob[idx].value;
      end else if (cdb_valid && int'(cdb_tag) == t) begin
        r = 1'b1;
        v = cdb_value;
      end
    end
  endtask

  task automatic model_reset();
    rob.delete();
    next_tag = 1;
  endtask

  // One cycle: compare outputs mid-cycle, then apply the edge to the model.
  task automatic step();
    bit          exp_ir, exp_acc, exp_rc, exp_com, exp_hc, qr;
    logic [31:0] qv;
    int          idx;
    @(negedge clk_in);
    #1;
    exp_ir  = rdy_in && !flush_in && (rob.size() < ROB_N);
    exp_acc = exp_ir && issue_valid;
    exp_rc  = exp_acc && issue_has_rd && (issue_rd != 0);
    exp_com = rdy_in && !flush_in && (rob.size() > 0) && rob[0].done;
    exp_hc  = exp_com && rob[0].has_rd && (rob[0].rd != 0);
    check("issue_ready", 32'(issue_ready), 32'(exp_ir));
    check("issue_tag", 32'(issue_tag), next_tag);
    check("rd_control", 32'(rd_control), 32'(exp_rc));
    if (exp_rc) begin
      check("rename_rd", 32'(rd), 32'(issue_rd));
      check("rename_q", 32'(Q_value), next_tag);
    end
    check("has_commit", 32'(has_commit), 32'(exp_hc));
    if (exp_hc) begin
      check("commit_target", 32'(commit_target), rob[0].rd);
      check("commit_q", 32'(Commit_Q), rob[0].tag);
      check("commit_v", Commit_V, rob[0].value);
    end
    query_expect(int'(query1_tag), qr, qv);
    check("query1_ready", 32'(query1_ready), 32'(qr));
    check("query1_value", query1_value, qv);
    query_expect(int'(query2_tag), qr, qv);
    check("query2_ready", 32'(query2_ready), 32'(qr));
    check("query2_value", query2_value, qv);
    @(posedge clk_in);
    if (rdy_in) begin
      if (flush_in) model_reset();
      else begin
        if (cdb_valid && cdb_tag != 0) begin
          idx = find(int'(cdb_tag));
          if (idx >= 0) begin
            rob[idx].done  = 1'b1;
            rob[idx].value = cdb_value;
          end
        end
        if (exp_com) void'(rob.pop_front());
        if (exp_acc) begin
          rob.push_back('{tag: next_tag, rd: int'(issue_rd), has_rd: issue_has_rd,
                          done: 1'b0, value: 32'h0});
          next_tag = (next_tag == ROB_N) ? 1 : next_tag + 1;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; flush_in = 1'b0; issue_valid = 1'b0; issue_has_rd = 1'b0;
    issue_rd = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    query1_tag = '0; query2_tag = '0;
  endtask

  task automatic do_issue(input bit has_rd, input logic [RW-1:0] r);
    idle();
    issue_valid = 1'b1; issue_has_rd = has_rd; issue_rd = r;
    step();
  endtask

  task automatic do_cdb(input logic [QW-1:0] t, input logic [31:0] v);
    idle();
    cdb_valid = 1'b1; cdb_tag = t; cdb_value = v;
    step();
  endtask

  task automatic do_flush();
    idle();
    flush_in = 1'b1;
    step();
  endtask

  task automatic rand_inputs();
    rdy_in       = ($urandom_range(9) != 0);
    flush_in     = ($urandom_range(39) == 0);
    issue_valid  = ($urandom_range(2) != 0);
    issue_has_rd = ($urandom_range(3) != 0);
    issue_rd     = RW'($urandom_range(31));
    cdb_valid    = $urandom_range(1);
    cdb_value    = $urandom;
    if (rob.size() > 0 && $urandom_range(3) != 0)
      cdb_tag = QW'(rob[$urandom_range(32'(rob.size() - 1))].tag);
    else
      cdb_tag = QW'($urandom_range(15));
    query1_tag = ($urandom_range(3) == 0) ? cdb_tag : QW'($urandom_range(15));
    query2_tag = QW'($urandom_range(15));
  endtask

  initial begin
    idle();
    rst_n_in = 1'b0;
    model_reset();
    #12;
    check("reset_issue_tag", 32'(issue_tag), 1);
    check("reset_has_commit", 32'(has_commit), 0);
    check("reset_rd_control", 32'(rd_control), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Basic rename, writeback and commit.
    do_issue(1'b1, 5'd5);
    do_cdb(4'd1, 32'hDEADBEEF);
    idle(); step();
    idle(); step();

    // Fill to capacity, then commit the head while a 16th issue is refused.
    do_flush();
    for (int i = 0; i < ROB_N; i++) do_issue(1'b1, RW'(i + 1));
    do_cdb(4'd1, 32'h1111);
    do_issue(1'b1, 5'd7);
    do_issue(1'b1, 5'd8);

    // Destination-less instructions retire silently.
    do_flush();
    do_issue(1'b1, 5'd0);
    do_issue(1'b0, 5'd9);
    do_cdb(4'd1, 32'hA);
    do_cdb(4'd2, 32'hB);
    idle(); step();
    idle(); step();

    // Out-of-order completion, in-order retirement.
    do_flush();
    do_issue(1'b1, 5'd1);
    do_issue(1'b1, 5'd2);
    do_issue(1'b1, 5'd3);
    do_cdb(4'd3, 32'h33);
    idle(); step();
    idle(); step();
    do_cdb(4'd1, 32'h11);
    do_cdb(4'd2, 32'h22);
    for (int i = 0; i < 3; i++) begin idle(); step(); end

    // Same-cycle CDB bypass to an operand query.
    do_flush();
    do_issue(1'b1, 5'd4);
    do_issue(1'b1, 5'd6);
    idle();
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 32'h42; query1_tag = 4'd2;
    step();

    // Flush with entries in flight, then a stall with a ready head.
    for (int i = 0; i < 2; i++) do_issue(1'b1, 5'd10);
    do_flush();
    for (int i = 0; i < 4; i++) do_issue(1'b1, RW'(i + 12));
    do_cdb(4'd1, 32'h55);
    for (int i = 0; i < 3; i++) begin
      idle();
      rdy_in = 1'b0; issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd3;
      cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 32'h77;
      step();
    end
    idle(); step();

    for (int n = 0; n < 3000; n++) begin rand_inputs(); step(); end

    // Asynchronous reset in the middle of traffic.
    idle();
    rst_n_in = 1'b0;
    #2;
    check("midreset_has_commit", 32'(has_commit), 0);
    check("midreset_issue_tag", 32'(issue_tag), 1);
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    for (int n = 0; n < 500; n++) begin rand_inputs(); step(); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
